// File: rtl/axi4_read_arbiter.sv
// rtl/axi4_read_arbiter.sv - round-robin arbiter sharing one AXI4 read port among NUM_M managers
//
// Ports:
//   aclk, areset                 clock, asynchronous active-high reset
//   m_ar*  (packed per manager)  manager AR channels; m_arready per manager
//   m_rvalid/m_rready            per-manager R handshake
//   m_rdata/m_rid/m_rresp/m_rlast R fields broadcast to every manager
//   s_ar*                        muxed AR channel to the subordinate
//   s_r*                         R channel from the subordinate
//   busy                         high while a burst is being arbitrated or in flight
`timescale 1ns/1ps
module axi4_read_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_M-1:0]        m_arvalid,
  output logic [NUM_M-1:0]        m_arready,
  input  logic [NUM_M*ADDR_W-1:0] m_araddr,
  input  logic [NUM_M*ID_W-1:0]   m_arid,
  input  logic [NUM_M*8-1:0]      m_arlen,
  input  logic [NUM_M*3-1:0]      m_arsize,
  input  logic [NUM_M*2-1:0]      m_arburst,
  output logic [NUM_M-1:0]        m_rvalid,
  input  logic [NUM_M-1:0]        m_rready,
  output logic [DATA_W-1:0]       m_rdata,
  output logic [ID_W-1:0]         m_rid,
  output logic [1:0]              m_rresp,
  output logic                    m_rlast,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  output logic [ADDR_W-1:0]       s_araddr,
  output logic [ID_W-1:0]         s_arid,
  output logic [7:0]              s_arlen,
  output logic [2:0]              s_arsize,
  output logic [1:0]              s_arburst,
  output logic                    s_arlock,
  output logic [3:0]              s_arcache,
  output logic [2:0]              s_arprot,
  output logic [3:0]              s_arqos,
  output logic [3:0]              s_arregion,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  input  logic [DATA_W-1:0]       s_rdata,
  input  logic [ID_W-1:0]         s_rid,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rlast,
  output logic                    busy
);

  localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic          found;
  logic [31:0]   idx;

  // Scan managers starting at rr_ptr, wrapping modulo NUM_M; first requester wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = 32'(rr_ptr) + 32'(k);
      if (idx >= 32'(NUM_M)) idx = idx - 32'(NUM_M);
      if (!found && m_arvalid[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant <= pick;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_arready) state <= ST_DATA;
        end
        ST_DATA: begin
          // Only rlast ends the burst; arlen is never counted here.
          if (s_rvalid && s_rready && s_rlast) begin
            state  <= ST_IDLE;
            rr_ptr <= (grant == GW'(NUM_M - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // AR fields follow the granted manager; managers hold them stable while valid.
  assign s_arvalid  = (state == ST_ADDR);
  assign s_araddr   = m_araddr [int'(grant)*ADDR_W +: ADDR_W];
  assign s_arid     = m_arid   [int'(grant)*ID_W   +: ID_W];
  assign s_arlen    = m_arlen  [int'(grant)*8      +: 8];
  assign s_arsize   = m_arsize [int'(grant)*3      +: 3];
  assign s_arburst  = m_arburst[int'(grant)*2      +: 2];
  assign s_arlock   = 1'b0;
  assign s_arcache  = 4'b0011;
  assign s_arprot   = 3'b000;
  assign s_arqos    = 4'b0000;
  assign s_arregion = 4'b0000;

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    if (state == ST_ADDR) m_arready[grant] = s_arready;
    if (state == ST_DATA) m_rvalid[grant]  = s_rvalid;
  end

  assign s_rready = (state == ST_DATA) && m_rready[grant];

  // R payload is broadcast; m_rvalid alone tells a manager the beat is its own.
  assign m_rdata = s_rdata;
  assign m_rid   = s_rid;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// tb/tb_axi4_read_arbiter.sv - directed self-checking bench for axi4_read_arbiter
`timescale 1ns/1ps
module tb_axi4_read_arbiter;

  logic          aclk = 1'b0;
  logic          areset;
  logic [1:0]    m_arvalid;
  logic [1:0]    m_arready;
  logic [127:0]  m_araddr;
  logic [1:0]    m_arid;
  logic [15:0]   m_arlen;
  logic [5:0]    m_arsize;
  logic [3:0]    m_arburst;
  logic [1:0]    m_rvalid;
  logic [1:0]    m_rready;
  logic [63:0]   m_rdata;
  logic [0:0]    m_rid;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          s_arvalid;
  logic          s_arready;
  logic [63:0]   s_araddr;
  logic [0:0]    s_arid;
  logic [7:0]    s_arlen;
  logic [2:0]    s_arsize;
  logic [1:0]    s_arburst;
  logic          s_arlock;
  logic [3:0]    s_arcache;
  logic [2:0]    s_arprot;
  logic [3:0]    s_arqos;
  logic [3:0]    s_arregion;
  logic          s_rvalid;
  logic          s_rready;
  logic [63:0]   s_rdata;
  logic [0:0]    s_rid;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  axi4_read_arbiter #(.NUM_M(2), .ADDR_W(64), .DATA_W(64), .ID_W(1)) dut (
    .aclk(aclk), .areset(areset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
    .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arregion(s_arregion),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus is applied at a falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge aclk);
  endtask

  // Runs one burst from IDLE to IDLE. Beat b carries data addr+b; the last beat carries rresp.
  task automatic do_burst(input string tag, input logic [1:0] req, input logic [1:0] exp_oh,
                          input logic [63:0] exp_addr, input int beats, input logic [1:0] last_resp);
    m_arvalid = req;
    cyc();
    s_arready = 1'b1;
    #1;
    check({tag, " arvalid"}, 64'(s_arvalid), 64'd1);
    check({tag, " araddr"}, s_araddr, exp_addr);
    check({tag, " arready"}, 64'(m_arready), 64'(exp_oh));
    cyc();
    s_arready = 1'b0;
    m_arvalid = req & ~exp_oh;
    m_rready  = 2'b11;
    for (int b = 0; b < beats; b++) begin
      s_rvalid = 1'b1;
      s_rdata  = exp_addr + 64'(b);
      s_rlast  = (b == beats - 1);
      s_rresp  = (b == beats - 1) ? last_resp : 2'b00;
      #1;
      check({tag, " rvalid"}, 64'(m_rvalid), 64'(exp_oh));
      check({tag, " rdata"}, m_rdata, exp_addr + 64'(b));
      if (b == beats - 1) check({tag, " rresp"}, 64'(m_rresp), 64'(last_resp));
      cyc();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    s_rresp  = 2'b00;
    m_arvalid = 2'b00;
    #1;
    check({tag, " busy end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic       tog;
    int         got_beats;
    areset    = 1'b1;
    m_arvalid = '0;
    m_araddr  = '0;
    m_arid    = 2'b01;
    m_arlen   = '0;
    m_arsize  = {3'd3, 3'd3};
    m_arburst = {2'b01, 2'b01};
    m_rready  = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rid     = '0;
    s_rresp   = '0;
    s_rlast   = 1'b0;
    cyc(); cyc();
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst s_arvalid", 64'(s_arvalid), 64'd0);
    check("rst m_arready", 64'(m_arready), 64'd0);
    check("rst m_rvalid", 64'(m_rvalid), 64'd0);
    check("rst s_rready", 64'(s_rready), 64'd0);
    check("arcache const", 64'(s_arcache), 64'h3);
    cyc();
    areset = 1'b0;

    // Single request, 4 beats to manager 0.
    m_araddr[63:0] = 64'h1000;
    m_arlen[7:0]   = 8'd3;
    m_arvalid      = 2'b01;
    #1;
    check("single idle busy", 64'(busy), 64'd0);
    cyc();
    #1;
    check("single busy", 64'(busy), 64'd1);
    check("single arlen", 64'(s_arlen), 64'd3);
    check("single arid", 64'(s_arid), 64'd1);
    check("single arready wait", 64'(m_arready), 64'd0);
    m_arvalid = 2'b00;
    do_burst("single", 2'b01, 2'b01, 64'h1000, 4, 2'b00);

    // Contention from reset: both request continuously, grant alternates 0,1,0,1.
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    m_araddr = {64'h200, 64'h100};
    do_burst("rr0", 2'b11, 2'b01, 64'h100, 1, 2'b00);
    do_burst("rr1", 2'b11, 2'b10, 64'h200, 1, 2'b00);
    do_burst("rr2", 2'b11, 2'b01, 64'h100, 1, 2'b00);
    do_burst("rr3", 2'b11, 2'b10, 64'h200, 1, 2'b00);

    // Backpressure: AR stalled 5 cycles, m_rready[1] toggled across a 3-beat burst.
    m_araddr[127:64] = 64'h3000;
    m_arlen[15:8]    = 8'd2;
    m_arvalid        = 2'b10;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp ar stall valid", 64'(s_arvalid), 64'd1);
      check("bp ar stall ready", 64'(m_arready), 64'd0);
      cyc();
    end
    s_arready = 1'b1;
    #1;
    check("bp arready", 64'(m_arready), 64'b10);
    cyc();
    s_arready = 1'b0;
    m_arvalid = 2'b00;
    tog = 1'b0;
    got_beats = 0;
    for (int c = 0; c < 20 && got_beats < 3; c++) begin
      s_rvalid = 1'b1;
      s_rdata  = 64'hB0 + 64'(got_beats);
      s_rlast  = (got_beats == 2);
      m_rready = {tog, 1'b0};
      #1;
      check("bp s_rready", 64'(s_rready), 64'(tog));
      check("bp rvalid", 64'(m_rvalid), 64'b10);
      check("bp rdata", m_rdata, 64'hB0 + 64'(got_beats));
      if (m_rvalid[1] && m_rready[1]) got_beats++;
      tog = ~tog;
      cyc();
    end
    check("bp beats", 64'(got_beats), 64'd3);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    check("bp busy end", 64'(busy), 64'd0);

    // Late request: mgr1 asks during mgr0 DATA, then gets an error response.
    m_araddr[63:0] = 64'h4000;
    m_arvalid = 2'b01;
    cyc();
    s_arready = 1'b1;
    cyc();
    s_arready = 1'b0;
    m_arvalid = 2'b10;
    m_rready  = 2'b11;
    s_rvalid  = 1'b1;
    s_rlast   = 1'b0;
    #1;
    check("late no preempt", 64'(m_rvalid), 64'b01);
    check("late arready", 64'(m_arready), 64'd0);
    cyc();
    s_rlast = 1'b1;
    cyc();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    check("late idle", 64'(busy), 64'd0);
    cyc();
    s_arready = 1'b1;
    #1;
    check("late grant1 addr", s_araddr, 64'h3000);
    check("late grant1 arready", 64'(m_arready), 64'b10);
    cyc();
    s_arready = 1'b0;
    m_arvalid = 2'b00;
    s_rvalid  = 1'b1;
    s_rlast   = 1'b1;
    s_rresp   = 2'b10;
    #1;
    check("err rvalid", 64'(m_rvalid), 64'b10);
    check("err rresp", 64'(m_rresp), 64'h2);
    cyc();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    s_rresp  = 2'b00;
    #1;
    check("err idle", 64'(busy), 64'd0);

    // Async reset mid-DATA: rr_ptr is 1 after a completed mgr0 burst, reset must clear it.
    do_burst("pre", 2'b01, 2'b01, 64'h4000, 1, 2'b00);
    m_arvalid = 2'b10;
    cyc();
    s_arready = 1'b1;
    cyc();
    s_arready = 1'b0;
    m_arvalid = 2'b00;
    s_rvalid  = 1'b1;
    for (int b = 0; b < 2; b++) cyc();
    #1;
    check("mid rvalid", 64'(m_rvalid), 64'b10);
    areset = 1'b1;
    #1;
    check("arst rvalid", 64'(m_rvalid), 64'd0);
    check("arst s_rready", 64'(s_rready), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    cyc();
    areset   = 1'b0;
    s_rvalid = 1'b0;
    do_burst("post rst", 2'b11, 2'b01, 64'h4000, 1, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
